// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the x32 load/store unit: funct3 encodings, FSM states,
// and byte-strobe/alignment helpers.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    // Access size comes from funct3[1:0]; 11 (unsupported) is treated as a word.
    function automatic logic [3:0] lsu_strobe(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << addr_lo;
            2'b01:   strb = 4'b0011 << addr_lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store lane alignment: byte strobes and lane-replicated write data.
module lsu_store_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    always_comb begin
        wstrb = lsu_strobe(funct3, addr_lo);
        case (funct3[1:0])
            2'b00:   wdata = {4{store_data[7:0]}};
            2'b01:   wdata = {2{store_data[15:0]}};
            default: wdata = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory. Defining LSU_MISALIGN_TRAP_EN
// adds the misalign_fault port and retires misaligned accesses without a bus request.
module load_store_unit
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ls_valid,
    output logic        ls_ready,
    input  logic        ls_is_store,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_store_data,
    input  logic [4:0]  ls_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        reg_write_enable,
    output logic        mem_read_enable,
    output logic [4:0]  reg_write_address,
    output logic [2:0]  load_operation,
    output logic [31:0] mem_read_data,
    output logic        ls_done,
    output logic        bus_error,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    output lsu_state_t  fsm_state
);

    // Handshake: execute's operation is taken on a rising edge where ls_valid and
    // ls_ready are both high; the bus request is taken where mem_req and mem_gnt are
    // both high; read data is taken only in RESP with mem_rvalid high.

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;
    logic        is_store_q;
    logic [1:0]  addr_lo_q;
    logic [7:0]  timer;
    logic        timed_out;

    lsu_store_align u_store_align (
        .funct3     (ls_funct3),
        .addr_lo    (ls_addr[1:0]),
        .store_data (ls_store_data),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata)
    );

    assign timed_out = (timer == TIMEOUT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = lsu_misaligned(ls_funct3, ls_addr[1:0]);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_state         <= LSU_IDLE;
            ls_ready          <= 1'b1;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wstrb         <= '0;
            mem_wdata         <= '0;
            reg_write_enable  <= 1'b0;
            mem_read_enable   <= 1'b0;
            reg_write_address <= '0;
            load_operation    <= '0;
            mem_read_data     <= '0;
            ls_done           <= 1'b0;
            bus_error         <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_fault    <= 1'b0;
`endif
            is_store_q        <= 1'b0;
            addr_lo_q         <= '0;
            timer             <= '0;
        end else begin
            ls_done          <= 1'b0;
            bus_error        <= 1'b0;
            reg_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_fault   <= 1'b0;
`endif
            case (fsm_state)
                LSU_IDLE: begin
                    if (ls_valid) begin
                        ls_ready          <= 1'b0;
                        is_store_q        <= ls_is_store;
                        addr_lo_q         <= ls_addr[1:0];
                        reg_write_address <= ls_rd;
                        load_operation    <= ls_funct3;
                        timer             <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            fsm_state      <= LSU_DONE;
                            ls_done        <= 1'b1;
                            misalign_fault <= 1'b1;
                        end else begin
                            fsm_state <= LSU_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= ls_is_store;
                            mem_addr  <= {ls_addr[31:2], 2'b00};
                            mem_wstrb <= ls_is_store ? align_wstrb : 4'b0000;
                            mem_wdata <= ls_is_store ? align_wdata : 32'h0;
                        end
`else
                        fsm_state <= LSU_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= ls_is_store;
                        mem_addr  <= {ls_addr[31:2], 2'b00};
                        mem_wstrb <= ls_is_store ? align_wstrb : 4'b0000;
                        mem_wdata <= ls_is_store ? align_wdata : 32'h0;
`endif
                    end
                end

                LSU_REQ: begin
                    if (mem_gnt || timed_out) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        mem_wdata <= 32'h0;
                    end
                    // A grant on the last allowed cycle still wins over the timeout.
                    if (mem_gnt) begin
                        timer <= '0;
                        if (is_store_q) begin
                            fsm_state <= LSU_DONE;
                            ls_done   <= 1'b1;
                        end else begin
                            fsm_state <= LSU_RESP;
                        end
                    end else if (timed_out) begin
                        fsm_state <= LSU_DONE;
                        ls_done   <= 1'b1;
                        bus_error <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                LSU_RESP: begin
                    if (mem_rvalid) begin
                        fsm_state     <= LSU_DONE;
                        ls_done       <= 1'b1;
                        mem_read_data <= mem_rdata >> {addr_lo_q, 3'b000};
                        if (reg_write_address != 5'd0) begin
                            reg_write_enable <= 1'b1;
                            mem_read_enable  <= 1'b1;
                        end
                    end else if (timed_out) begin
                        fsm_state <= LSU_DONE;
                        ls_done   <= 1'b1;
                        bus_error <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                LSU_DONE: begin
                    fsm_state <= LSU_IDLE;
                    ls_ready  <= 1'b1;
                end

                default: begin
                    fsm_state <= LSU_IDLE;
                    ls_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: bus requests and load writebacks are
// predicted at drive time and compared when the unit produces them.
module tb_load_store_unit;
    import rv32_mem_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset_n;
    logic        ls_valid;
    logic        ls_ready;
    logic        ls_is_store;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_store_data;
    logic [4:0]  ls_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        reg_write_enable;
    logic        mem_read_enable;
    logic [4:0]  reg_write_address;
    logic [2:0]  load_operation;
    logic [31:0] mem_read_data;
    logic        ls_done;
    logic        bus_error;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif
    lsu_state_t  fsm_state;

    int n_checks = 0;
    int n_fails  = 0;

    logic [68:0] bus_q[$];
    logic [39:0] wb_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ls_valid          (ls_valid),
        .ls_ready          (ls_ready),
        .ls_is_store       (ls_is_store),
        .ls_funct3         (ls_funct3),
        .ls_addr           (ls_addr),
        .ls_store_data     (ls_store_data),
        .ls_rd             (ls_rd),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wstrb         (mem_wstrb),
        .mem_wdata         (mem_wdata),
        .mem_gnt           (mem_gnt),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .reg_write_enable  (reg_write_enable),
        .mem_read_enable   (mem_read_enable),
        .reg_write_address (reg_write_address),
        .load_operation    (load_operation),
        .mem_read_data     (mem_read_data),
        .ls_done           (ls_done),
        .bus_error         (bus_error),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_fault    (misalign_fault),
`endif
        .fsm_state         (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [68:0] got, input logic [68:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        int sz;
        sz = size_of(f3);
        s = 4'b0000;
        if (sz == 4) s = 4'b1111;
        else for (int i = 0; i < 4; i++) if (i >= int'(a) && i < int'(a) + sz) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = size_of(f3);
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic model_misaligned(input logic [2:0] f3, input logic [1:0] a);
        int sz;
        sz = size_of(f3);
        return (sz == 2 && a[0]) || (sz == 4 && a != 2'b00);
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_req && mem_gnt) begin
                if (bus_q.size() == 0) check_eq("bus_unexpected", mem_req, 1'b0);
                else check_eq("bus_req", {mem_addr, mem_we, mem_wstrb, mem_wdata}, bus_q.pop_front());
            end
            if (reg_write_enable || mem_read_enable) begin
                check_eq("read_en_match", mem_read_enable, reg_write_enable);
                if (wb_q.size() == 0) check_eq("wb_unexpected", reg_write_enable, 1'b0);
                else check_eq("wb", {reg_write_address, load_operation, mem_read_data}, wb_q.pop_front());
            end
        end
    end

    // Driver: runs one operation to completion, answering the bus with the given delays.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd, input int gnt_dly,
                         input int rv_dly, input logic [31:0] rdata, output int lat, output int reqc);
        bit mis, exp_err, granted, saw_req;
        int respc;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = model_misaligned(f3, addr[1:0]);
`endif
        exp_err = !mis && (gnt_dly >= TIMEOUT || (!st && rv_dly >= TIMEOUT));
        check_eq("ls_ready_pre", ls_ready, 1'b1);
        if (!mis && gnt_dly < TIMEOUT)
            bus_q.push_back({addr[31:2], 2'b00, st, st ? model_strb(f3, addr[1:0]) : 4'b0000,
                             st ? model_wdata(f3, data) : 32'h0});
        if (!mis && !exp_err && !st && rd != 5'd0)
            wb_q.push_back({rd, f3, rdata >> (8 * addr[1:0])});
        ls_valid = 1'b1; ls_is_store = st; ls_funct3 = f3; ls_addr = addr;
        ls_store_data = data; ls_rd = rd;
        @(posedge clk); #1;
        ls_valid = 1'b0; ls_store_data = $urandom; ls_addr = $urandom;
        lat = 2; reqc = 0; respc = 0; granted = 1'b0; saw_req = 1'b0;
        while (!ls_done && lat < 100) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
            if (mem_req) begin
                saw_req = 1'b1;
                if (reqc == gnt_dly) begin
                    mem_gnt = 1'b1; granted = 1'b1;
                    if (!st) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
                end
                reqc++;
            end else if (granted && !st) begin
                if (respc == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
                respc++;
            end
            @(posedge clk); #1;
            lat++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        check_eq("ls_done", ls_done, 1'b1);
        check_eq("bus_error", bus_error, exp_err);
        check_eq("mem_req_at_done", mem_req, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("misalign_fault", misalign_fault, mis);
        check_eq("req_issued", saw_req, !mis);
`else
        check_eq("req_issued", saw_req, 1'b1);
`endif
        @(posedge clk); #1;
        check_eq("done_pulse", ls_done, 1'b0);
        check_eq("wb_pulse", reg_write_enable, 1'b0);
        check_eq("ls_ready_post", ls_ready, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, ls_ready, 1'b1);
        check_eq({tag, "_bus"}, {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata}, '0);
        check_eq({tag, "_wb"}, {reg_write_enable, mem_read_enable, reg_write_address,
                                load_operation, mem_read_data}, '0);
        check_eq({tag, "_done"}, {ls_done, bus_error}, 2'b00);
        check_eq({tag, "_state"}, fsm_state, LSU_IDLE);
    endtask

    int lat, reqc;

    initial begin
        reset_n = 1'b0; ls_valid = 1'b0; ls_is_store = 1'b0; ls_funct3 = 3'b0;
        ls_addr = 32'h0; ls_store_data = 32'h0; ls_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset");

        do_op(1'b1, F3_SW, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0, lat, reqc);
        check_eq("sw_latency", lat, 3);
        do_op(1'b1, F3_SB, 32'h103, 32'h0000_00AB, 5'd0, 0, 0, 32'h0, lat, reqc);
        check_eq("sb_latency", lat, 3);
        do_op(1'b1, F3_SH, 32'h202, 32'h1234_5678, 5'd0, 2, 0, 32'h0, lat, reqc);
        do_op(1'b0, F3_LH, 32'h102, 32'h0, 5'd5, 0, 0, 32'h8001_1234, lat, reqc);
        check_eq("lh_latency", lat, 4);
        do_op(1'b0, F3_LW, 32'h200, 32'h0, 5'd7, 255, 0, 32'h0, lat, reqc);
        check_eq("req_timeout_cycles", reqc, TIMEOUT);
        check_eq("req_timeout_latency", lat, TIMEOUT + 2);
        do_op(1'b0, F3_LW, 32'h400, 32'h0, 5'd8, 0, 255, 32'h0, lat, reqc);
        check_eq("resp_timeout_latency", lat, TIMEOUT + 3);
        do_op(1'b0, F3_LW, 32'h300, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D, lat, reqc);
        do_op(1'b0, F3_LBU, 32'h301, 32'h0, 5'd9, 3, 2, 32'h1122_3344, lat, reqc);
        do_op(1'b0, 3'b111, 32'h500, 32'h0, 5'd10, 1, 1, 32'hA5A5_0F0F, lat, reqc);

        // Stray response while idle must not write back.
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        check_eq("idle_rvalid_state", fsm_state, LSU_IDLE);
        check_eq("idle_rvalid_ready", ls_ready, 1'b1);

        // Reset while the request is outstanding.
        ls_valid = 1'b1; ls_is_store = 1'b0; ls_funct3 = F3_LW; ls_addr = 32'h600; ls_rd = 5'd3;
        @(posedge clk); #1;
        ls_valid = 1'b0;
        check_eq("mid_req_req", mem_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_drop_req", mem_req, 1'b0);
        check_reset_values("reset_in_req");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Reset during RESP, then a late response.
        bus_q.push_back({32'h0000_0700, 1'b0, 4'b0000, 32'h0});
        ls_valid = 1'b1; ls_is_store = 1'b0; ls_funct3 = F3_LW; ls_addr = 32'h700; ls_rd = 5'd4;
        @(posedge clk); #1;
        ls_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check_eq("in_resp", fsm_state, LSU_RESP);
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_in_resp");
        @(posedge clk); #1;
        reset_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        repeat (2) @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        check_reset_values("late_rvalid");

`ifdef LSU_MISALIGN_TRAP_EN
        do_op(1'b0, F3_LW, 32'h101, 32'h0, 5'd6, 0, 0, 32'h1111_2222, lat, reqc);
        check_eq("misalign_latency", lat, 2);
        do_op(1'b1, F3_SH, 32'h103, 32'hBEEF, 5'd0, 0, 0, 32'h0, lat, reqc);
`endif

        for (int i = 0; i < 24; i++) begin
            bit st;
            logic [2:0] f3;
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            do_op(st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, lat, reqc);
        end

        repeat (2) @(posedge clk);
        #1;
        check_eq("bus_q_empty", bus_q.size(), 0);
        check_eq("wb_q_empty", wb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit for the x32 core, sitting between the execute stage and data memory and feeding the register file's load write port. Accepts one memory operation at a time from execute. Drives a request/grant/response data bus with byte strobes and lane-shifts load data into the low bits. Hands the register file `mem_read_data`, `load_operation` and a write strobe; sign/zero extension stays in the register file.

## Interface
- `TIMEOUT_CYCLES`, 16: max cycles waiting for grant or response before `bus_error`; legal range 1..255.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ls_valid` in 1: execute presents an operation.
- `ls_ready` out 1: unit can accept; high only in IDLE.
- `ls_is_store` in 1: 1 = store, 0 = load.
- `ls_funct3` in 3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `ls_addr` in 32: byte address from ALU.
- `ls_store_data` in 32: rs2 value.
- `ls_rd` in 5: load destination register.
- `mem_req` out 1: bus request, held until `mem_gnt`.
- `mem_we` out 1: write request.
- `mem_addr` out 32: word-aligned address, `{ls_addr[31:2], 2'b00}`.
- `mem_wstrb` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: bus accepts the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `reg_write_enable` out 1: one-cycle load writeback strobe.
- `mem_read_enable` out 1: equals `reg_write_enable`; selects the register file load path.
- `reg_write_address` out 5: captured `ls_rd`.
- `load_operation` out 3: captured funct3.
- `mem_read_data` out 32: lane-shifted word, `mem_rdata >> (8*addr[1:0])`.
- `ls_done` out 1: one-cycle pulse when an operation retires, including on error or fault.
- `bus_error` out 1: one-cycle pulse, coincident with `ls_done`, on timeout.
- `misalign_fault` out 1: one-cycle pulse on a misaligned access; present only with the macro.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - `ls_ready`=1.
  - On `ls_valid`, capture addr, funct3, rd, store flag and data, then go to REQ.
- REQ:
  - `mem_req`=1 with address, strobe and data stable.
  - On `mem_gnt`: a store goes to DONE; a load goes to RESP.
- RESP:
  - Wait for `mem_rvalid`.
  - Capture the lane-shifted data and go to DONE.
- DONE:
  - Pulse `ls_done`.
  - For loads, also pulse `reg_write_enable` and `mem_read_enable`.
  - Return to IDLE.
- Store strobes: SB `4'b0001<<a`; SH `4'b0011<<a`; SW `4'b1111`, where a = `addr[1:0]`.
- Store data: SB `{4{d[7:0]}}`; SH `{2{d[15:0]}}`; SW `d`.
- Loads to `rd`=0 perform the bus access but suppress `reg_write_enable`.
- Timeout counter:
  - 8-bit, cleared on entry to REQ and to RESP; increments every cycle in those states.
  - At `TIMEOUT_CYCLES` it forces DONE with `bus_error`=1 and no writeback.
- Unsupported funct3 (011, 110, 111) is treated as a 4-byte access with `load_operation` passed through unchanged.
- `mem_rvalid` outside RESP is ignored. `mem_gnt` outside REQ is ignored.

## Timing
- Reset values: `ls_ready`=1; all other outputs 0; FSM in IDLE.
- `reset_n` low clears state asynchronously and drops `mem_req` immediately. This includes reset mid-REQ and mid-RESP.
- A late `mem_rvalid` after reset is ignored.
- All outputs are registered.
- Minimum latency from acceptance to `ls_done`, with `mem_gnt` and `mem_rvalid` both on their first eligible cycle:
  - Store: 3 cycles (accept, REQ, DONE).
  - Load: 4 cycles.
- `mem_rvalid` in the same cycle as `mem_gnt` is not consumed. The response must arrive at least one cycle after the grant.
- Back-to-back operations: the next operation is accepted in the cycle after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access goes IDLE→DONE with no bus request.
  - Misaligned means: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Pulses `misalign_fault` with `ls_done`; no writeback.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No check; the `misalign_fault` port is absent.
  - Misaligned accesses issue to the aligned word; strobes are masked to 4 bits and lanes shift out the top.

## Structure
- Package `rv32_mem_pkg`:
  - funct3 localparams (LB..LHU, SB/SH/SW).
  - FSM state enum `lsu_state_t`.
  - Function `lsu_strobe(funct3, addr_lo)`.
- One sub-module, `lsu_store_align`: combinational strobe and data replication.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, gnt immediate → `mem_wstrb`=1111, `mem_wdata`=0xDEADBEEF, `ls_done` at cycle 3, no `reg_write_enable`.
- SB to 0x103 with data 0x000000AB → `mem_wstrb`=1000, `mem_wdata`=0xABABABAB, `mem_addr`=0x100.
- LH to 0x102, rd=5, `mem_rdata`=0x8001_1234 one cycle after gnt → `mem_read_data`=0x00008001, `load_operation`=001, `reg_write_address`=5, one-cycle write strobe.
- LW with gnt withheld for 16 cycles → `bus_error` and `ls_done` pulse together, `mem_req` drops, no writeback, `ls_ready` returns to 1.
- `reset_n` low during RESP, then `mem_rvalid` arrives → FSM stays in IDLE, no writeback, all outputs at reset values.
- With macro defined, LW to 0x101 → `misalign_fault`=1 with `ls_done`, `mem_req` never asserted.
